// File: rtl/gpio_debouncer.sv
// Per-bit switch debouncer: 2-flop sync, stable-count filter, sticky change flag.
// Define GPIO_DEBOUNCER_EDGE_EN to add registered rise_o/fall_o edge pulses.

module gpio_debouncer_bit #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw,
  output logic gpio,
`ifdef GPIO_DEBOUNCER_EDGE_EN
  output logic rise,
  output logic fall,
`endif
  output logic upd
);
  localparam int unsigned     CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {STABLE, PENDING} state_t;

  state_t        state, state_nxt;
  logic          sync1, sync2;
  logic [CW-1:0] cnt, cnt_nxt, cnt_cur;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= sw;
      sync2 <= sync1;
    end
  end

  // The first differing cycle counts as stable cycle one, so STABLE acts as count 0.
  assign cnt_cur = (state == PENDING) ? cnt : '0;

  always_comb begin
    state_nxt = STABLE;
    cnt_nxt   = '0;
    upd       = 1'b0;
    if (sync2 != gpio) begin
      if (cnt_cur == LAST) begin
        upd = 1'b1;
      end else begin
        state_nxt = PENDING;
        cnt_nxt   = cnt_cur + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= STABLE;
      cnt   <= '0;
      gpio  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (upd) gpio <= sync2;
    end
  end

`ifdef GPIO_DEBOUNCER_EDGE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= upd & sync2;
      fall <= upd & ~sync2;
    end
  end
`endif
endmodule

module gpio_debouncer #(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] sw_i,
  output logic [WIDTH-1:0] gpio_o,
  output logic             change_o,
`ifdef GPIO_DEBOUNCER_EDGE_EN
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
`endif
  input  logic             ack_i
);
  logic [WIDTH-1:0] upd;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      gpio_debouncer_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_bit (
        .clk   (clk_i),
        .rst_n (reset_i),
        .sw    (sw_i[i]),
        .gpio  (gpio_o[i]),
`ifdef GPIO_DEBOUNCER_EDGE_EN
        .rise  (rise_o[i]),
        .fall  (fall_o[i]),
`endif
        .upd   (upd[i])
      );
    end
  endgenerate

  // A fresh update wins over a coincident ack so no change is ever lost.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i)     change_o <= 1'b0;
    else if (|upd)    change_o <= 1'b1;
    else if (ack_i)   change_o <= 1'b0;
  end
endmodule

// File: tb/tb_gpio_debouncer.sv
// Scoreboard bench for gpio_debouncer (WIDTH=8, DEBOUNCE_CYCLES=4); expectations
// are queued per cycle when stimulus is driven and popped as cycles elapse.
module tb_gpio_debouncer;
  logic       clk_i = 1'b0;
  logic       reset_i;
  logic [7:0] sw_i;
  logic [7:0] gpio_o;
  logic       change_o;
  logic       ack_i;
`ifdef GPIO_DEBOUNCER_EDGE_EN
  logic [7:0] rise_o, fall_o;
`endif

  gpio_debouncer #(.WIDTH(8), .DEBOUNCE_CYCLES(4)) dut (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .sw_i     (sw_i),
    .gpio_o   (gpio_o),
    .change_o (change_o),
`ifdef GPIO_DEBOUNCER_EDGE_EN
    .rise_o   (rise_o),
    .fall_o   (fall_o),
`endif
    .ack_i    (ack_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int         cyc;
    logic [7:0] gpio;
    logic       chg;
    logic       edge_chk;
    logic [7:0] rise;
    logic [7:0] fall;
    string      name;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks   = 0;
  int   failures = 0;

  task automatic step;
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(string nm, int a, int b, logic [7:0] g, logic c);
    for (int i = a; i <= b; i++) begin
      exp_t x;
      x.cyc = i; x.gpio = g; x.chg = c; x.edge_chk = 1'b0;
      x.rise = 8'h00; x.fall = 8'h00; x.name = nm;
      sb.push_back(x);
    end
  endtask

  task automatic do_reset;
    reset_i = 1'b0; sw_i = 8'h00; ack_i = 1'b0;
    step; step;
    reset_i = 1'b1;
  endtask

  task automatic test_reset;
    sw_i = 8'hFF; ack_i = 1'b0; reset_i = 1'b0;
    push("reset_hold", 1, 10, 8'h00, 1'b0);
    push("reset_wait", 11, 15, 8'h00, 1'b0);
    push("reset_rel", 16, 18, 8'hFF, 1'b1);
    for (int r = 1; r <= 18; r++) begin
      step;
      while (sb.size() > 0 && sb[0].cyc == r) begin
        e = sb.pop_front(); checks++;
        if (gpio_o !== e.gpio || change_o !== e.chg) begin
          failures++;
          $display("FAIL %s cyc=%0d got gpio_o=%h change_o=%b want gpio_o=%h change_o=%b",
                   e.name, r, gpio_o, change_o, e.gpio, e.chg);
        end
      end
      if (r == 10) reset_i = 1'b1;
    end
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL reset_sb left=%0d want 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_glitch;
    do_reset;
    sw_i = 8'h01;
    push("glitch", 1, 12, 8'h00, 1'b0);
    for (int r = 1; r <= 12; r++) begin
      step;
      while (sb.size() > 0 && sb[0].cyc == r) begin
        e = sb.pop_front(); checks++;
        if (gpio_o !== e.gpio || change_o !== e.chg) begin
          failures++;
          $display("FAIL %s cyc=%0d got gpio_o=%h change_o=%b want gpio_o=%h change_o=%b",
                   e.name, r, gpio_o, change_o, e.gpio, e.chg);
        end
      end
      if (r == 3) sw_i = 8'h00;
    end
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL glitch_sb left=%0d want 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_independent;
    do_reset;
    sw_i = 8'h81;
    push("indep_wait", 1, 5, 8'h00, 1'b0);
    push("indep_bit0", 6, 9, 8'h01, 1'b1);
    push("indep_bit7", 10, 12, 8'h81, 1'b1);
    for (int r = 1; r <= 12; r++) begin
      step;
      while (sb.size() > 0 && sb[0].cyc == r) begin
        e = sb.pop_front(); checks++;
        if (gpio_o !== e.gpio || change_o !== e.chg) begin
          failures++;
          $display("FAIL %s cyc=%0d got gpio_o=%h change_o=%b want gpio_o=%h change_o=%b",
                   e.name, r, gpio_o, change_o, e.gpio, e.chg);
        end
      end
      if (r == 3) sw_i = 8'h01;
      if (r == 4) sw_i = 8'h81;
    end
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL indep_sb left=%0d want 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_ack_collision;
    do_reset;
    sw_i = 8'h01;
    push("ack_wait", 1, 5, 8'h00, 1'b0);
    push("ack_set", 6, 11, 8'h01, 1'b1);
    push("ack_collide", 12, 12, 8'h03, 1'b1);
    push("ack_clear", 13, 20, 8'h03, 1'b0);
    push("ack_fall_set", 21, 22, 8'h02, 1'b1);
    for (int r = 1; r <= 22; r++) begin
      step;
      while (sb.size() > 0 && sb[0].cyc == r) begin
        e = sb.pop_front(); checks++;
        if (gpio_o !== e.gpio || change_o !== e.chg) begin
          failures++;
          $display("FAIL %s cyc=%0d got gpio_o=%h change_o=%b want gpio_o=%h change_o=%b",
                   e.name, r, gpio_o, change_o, e.gpio, e.chg);
        end
      end
      if (r == 6)  sw_i  = 8'h03;
      if (r == 11) ack_i = 1'b1;
      if (r == 14) ack_i = 1'b0;
      if (r == 15) sw_i  = 8'h02;
    end
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL ack_sb left=%0d want 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_reset_mid_count;
    do_reset;
    sw_i = 8'h10;
    push("midrst_wait", 1, 9, 8'h00, 1'b0);
    push("midrst_upd", 10, 12, 8'h10, 1'b1);
    for (int r = 1; r <= 12; r++) begin
      step;
      while (sb.size() > 0 && sb[0].cyc == r) begin
        e = sb.pop_front(); checks++;
        if (gpio_o !== e.gpio || change_o !== e.chg) begin
          failures++;
          $display("FAIL %s cyc=%0d got gpio_o=%h change_o=%b want gpio_o=%h change_o=%b",
                   e.name, r, gpio_o, change_o, e.gpio, e.chg);
        end
      end
      if (r == 3) reset_i = 1'b0;
      if (r == 4) reset_i = 1'b1;
    end
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL midrst_sb left=%0d want 0", sb.size()); sb.delete(); end
  endtask

`ifdef GPIO_DEBOUNCER_EDGE_EN
  task automatic test_edges;
    do_reset;
    sw_i = 8'h02;
    push("edge_wait", 1, 5, 8'h00, 1'b0);
    push("edge_high", 6, 15, 8'h02, 1'b1);
    push("edge_low", 16, 20, 8'h00, 1'b1);
    foreach (sb[i]) begin
      sb[i].edge_chk = 1'b1;
      sb[i].rise = (sb[i].cyc == 6)  ? 8'h02 : 8'h00;
      sb[i].fall = (sb[i].cyc == 16) ? 8'h02 : 8'h00;
    end
    for (int r = 1; r <= 20; r++) begin
      step;
      while (sb.size() > 0 && sb[0].cyc == r) begin
        e = sb.pop_front(); checks++;
        if (gpio_o !== e.gpio || change_o !== e.chg ||
            (e.edge_chk && (rise_o !== e.rise || fall_o !== e.fall))) begin
          failures++;
          $display("FAIL %s cyc=%0d got gpio_o=%h change_o=%b rise_o=%h fall_o=%h want %h %b %h %h",
                   e.name, r, gpio_o, change_o, rise_o, fall_o, e.gpio, e.chg, e.rise, e.fall);
        end
      end
      if (r == 10) sw_i = 8'h00;
    end
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL edge_sb left=%0d want 0", sb.size()); sb.delete(); end
  endtask
`endif

  initial begin
    reset_i = 1'b0; sw_i = 8'hFF; ack_i = 1'b0;
    test_reset;
    test_glitch;
    test_independent;
    test_ack_collision;
    test_reset_mid_count;
`ifdef GPIO_DEBOUNCER_EDGE_EN
    test_edges;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end
endmodule
